pet2001_key_sched: RTL and testbench

PET2001_KEY_SCHED -- requirements
Module: pet2001_key_sched

---
 rtl/pet2001_key_pkg.sv | 36 +++
 rtl/pet2001_ascii_map.sv | 92 +++++++++
 rtl/pet2001_key_sched.sv | 166 ++++++++++++++++
 tb/tb_pet2001_key_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pet2001_key_pkg.sv
// Shared types and constants for the PET 2001 UART keyboard scheduler:
// FSM state encoding, the shift-key position and the key-code record.
package pet2001_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SHIFT_LEAD,
        PRESS,
        RELEASE,
        GAP
    } state_t;

    // Left shift lives at row 8, column 0 of the PET matrix
    localparam logic [3:0] SHIFT_ROW = 4'd8;
    localparam logic [2:0] SHIFT_COL = 3'd0;
    localparam logic [3:0] NUM_ROWS  = 4'd10;

    typedef struct packed {
        logic       valid;
        logic       shift;
        logic [3:0] row;
        logic [2:0] col;
    } key_code_t;

    // Build an unshifted, valid key code for a matrix position
    function automatic key_code_t key_at(input logic [3:0] row, input logic [2:0] col);
        key_code_t k;
        k.valid = 1'b1;
        k.shift = 1'b0;
        k.row   = row;
        k.col   = col;
        return k;
    endfunction

endpackage

// File: rtl/pet2001_ascii_map.sv
// ASCII byte to PET 2001 keyboard matrix translation (purely combinational).
// Upper-case letters, digits and the punctuation printed on the PET keys are
// unshifted; lower-case letters and !"#$%&'() are produced with shift held.
module pet2001_ascii_map
    import pet2001_key_pkg::*;
(
    input  logic [7:0] data,
    output key_code_t  code
);

    logic [7:0] base;
    logic       shifted;

    // Fold shifted characters onto their base key, then look up the matrix position
    always_comb begin
        base    = data;
        shifted = 1'b0;
        if (data >= 8'h61 && data <= 8'h7A) begin
            base    = data - 8'h20;
            shifted = 1'b1;
        end else if (data >= 8'h21 && data <= 8'h29) begin
            base    = data + 8'h10;
            shifted = 1'b1;
        end

        code = '0;
        case (base)
            8'h08: code = key_at(4'd1, 3'd7);          // DEL
            8'h0A: code = key_at(4'd6, 3'd5);          // LF -> RETURN
            8'h0D: code = key_at(4'd6, 3'd5);          // RETURN
            8'h20: code = key_at(4'd9, 3'd2);
            8'h2A: code = key_at(4'd5, 3'd7);
            8'h2B: code = key_at(4'd7, 3'd7);
            8'h2C: code = key_at(4'd7, 3'd3);
            8'h2D: code = key_at(4'd8, 3'd7);
            8'h2E: code = key_at(4'd9, 3'd6);
            8'h2F: code = key_at(4'd3, 3'd7);
            8'h30: code = key_at(4'd8, 3'd6);
            8'h31: code = key_at(4'd6, 3'd6);
            8'h32: code = key_at(4'd7, 3'd6);
            8'h33: code = key_at(4'd6, 3'd7);
            8'h34: code = key_at(4'd4, 3'd6);
            8'h35: code = key_at(4'd5, 3'd6);
            8'h36: code = key_at(4'd4, 3'd7);
            8'h37: code = key_at(4'd2, 3'd6);
            8'h38: code = key_at(4'd3, 3'd6);
            8'h39: code = key_at(4'd2, 3'd7);
            8'h3A: code = key_at(4'd5, 3'd4);
            8'h3B: code = key_at(4'd6, 3'd4);
            8'h3C: code = key_at(4'd9, 3'd3);
            8'h3D: code = key_at(4'd9, 3'd7);
            8'h3E: code = key_at(4'd8, 3'd4);
            8'h3F: code = key_at(4'd7, 3'd4);
            8'h40: code = key_at(4'd8, 3'd1);
            8'h41: code = key_at(4'd4, 3'd0);
            8'h42: code = key_at(4'd6, 3'd2);
            8'h43: code = key_at(4'd6, 3'd1);
            8'h44: code = key_at(4'd4, 3'd1);
            8'h45: code = key_at(4'd2, 3'd1);
            8'h46: code = key_at(4'd5, 3'd1);
            8'h47: code = key_at(4'd4, 3'd2);
            8'h48: code = key_at(4'd5, 3'd2);
            8'h49: code = key_at(4'd3, 3'd3);
            8'h4A: code = key_at(4'd4, 3'd3);
            8'h4B: code = key_at(4'd5, 3'd3);
            8'h4C: code = key_at(4'd4, 3'd4);
            8'h4D: code = key_at(4'd6, 3'd3);
            8'h4E: code = key_at(4'd7, 3'd2);
            8'h4F: code = key_at(4'd2, 3'd4);
            8'h50: code = key_at(4'd3, 3'd4);
            8'h51: code = key_at(4'd2, 3'd0);
            8'h52: code = key_at(4'd3, 3'd1);
            8'h53: code = key_at(4'd5, 3'd0);
            8'h54: code = key_at(4'd2, 3'd2);
            8'h55: code = key_at(4'd2, 3'd3);
            8'h56: code = key_at(4'd7, 3'd1);
            8'h57: code = key_at(4'd3, 3'd0);
            8'h58: code = key_at(4'd7, 3'd0);
            8'h59: code = key_at(4'd3, 3'd2);
            8'h5A: code = key_at(4'd6, 3'd0);
            8'h5B: code = key_at(4'd9, 3'd1);
            8'h5C: code = key_at(4'd1, 3'd3);
            8'h5D: code = key_at(4'd8, 3'd2);
            default: code = '0;
        endcase

        if (code.valid) begin
            code.shift = shifted;
        end
    end

endmodule

// File: rtl/pet2001_key_sched.sv
// PET 2001 keyboard scheduler: queues UART bytes and replays each one as a
// timed key press on the emulated keyboard matrix (optional shift lead,
// press, shift release, key-up gap). One byte is in flight at a time.
// Optional feature: define PET2001_KEY_SCHED_LF_DROP_EN to discard 0x0A at
// the FIFO input instead of typing it as RETURN.
module pet2001_key_sched
    import pet2001_key_pkg::*;
#(
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_data,
    input  logic       uart_strobe,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       busy,
    output logic       overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // Counters load duration-1 so a state lasts exactly its duration
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          byte_ok, push_req, push, pop, drop;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [7:0]    cur_byte;
    key_code_t     code;
    logic          key_on, shift_on;
    logic [7:0]    cols;

`ifdef PET2001_KEY_SCHED_LF_DROP_EN
    assign byte_ok = (uart_data != 8'h0A);
`else
    assign byte_ok = 1'b1;
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
    assign pop      = (state == IDLE) && !fifo_empty;
    assign push_req = uart_strobe && byte_ok;
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    assign busy = (state != IDLE) || !fifo_empty;

    pet2001_ascii_map u_map (
        .data (cur_byte),
        .code (code)
    );

    // FIFO pointers and the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage and the in-flight byte (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= uart_data;
        if (pop)  cur_byte <= mem[rd_ptr[AW-1:0]];
    end

    // FSM state and duration counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    // Next-state logic: each timed state exits when its counter reaches zero
    always_comb begin
        nxt_state = state;
        nxt_cnt   = (cnt != '0) ? cnt - CNT_ONE : cnt;
        case (state)
            IDLE: begin
                if (!fifo_empty) nxt_state = LOOKUP;
            end
            LOOKUP: begin
                if (!code.valid) begin
                    nxt_state = IDLE;
                end else if (code.shift) begin
                    nxt_state = SHIFT_LEAD;
                    nxt_cnt   = GAP_LD;
                end else begin
                    nxt_state = PRESS;
                    nxt_cnt   = HOLD_LD;
                end
            end
            SHIFT_LEAD: begin
                if (cnt == '0) begin
                    nxt_state = PRESS;
                    nxt_cnt   = HOLD_LD;
                end
            end
            PRESS: begin
                if (cnt == '0) begin
                    nxt_state = RELEASE;
                    nxt_cnt   = code.shift ? GAP_LD : '0;
                end
            end
            RELEASE: begin
                if (cnt == '0) begin
                    nxt_state = GAP;
                    nxt_cnt   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt == '0) nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    assign key_on   = (state == PRESS);
    assign shift_on = (state == SHIFT_LEAD) ||
                      (((state == PRESS) || (state == RELEASE)) && code.shift);

    // Column pattern for the row being scanned (active-high before inversion)
    always_comb begin
        cols = '0;
        if (keyrow < NUM_ROWS) begin
            if (key_on && (code.row == keyrow)) cols[code.col] = 1'b1;
            if (shift_on && (keyrow == SHIFT_ROW)) cols[SHIFT_COL] = 1'b1;
        end
    end

    // Registered active-low column return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keyin <= 8'hFF;
        end else begin
            keyin <= ~cols;
        end
    end

endmodule

// File: tb/tb_pet2001_key_sched.sv
// Directed bench for pet2001_key_sched with HOLD=8, GAP=4, FIFO depth 4.
// Sample index k means "at the falling edge after the k-th rising edge
// following the cycle in which the strobe was driven".
module tb_pet2001_key_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_data;
    logic       uart_strobe;
    logic [3:0] keyrow;
    logic [7:0] keyin;
    logic       busy;
    logic       overflow;

    int passed = 0;
    int total  = 0;

    pet2001_key_sched #(
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_data   (uart_data),
        .uart_strobe (uart_strobe),
        .keyrow      (keyrow),
        .keyin       (keyin),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] row;
        int         first;
        int         last;
        logic [7:0] low;
        int         clear;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] burst_b [6];
    logic [7:0] burst_exp [6];
    logic [7:0] run_val [8];
    int         run_len [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s idle", tag), 32'(busy), 32'(0));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] exp;
        @(negedge clk);
        keyrow      = v.row;
        uart_data   = v.data;
        uart_strobe = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            uart_strobe = 1'b0;
            exp = (k >= v.first && k <= v.last) ? v.low : 8'hFF;
            check($sformatf("v%0d keyin s%0d", idx, k), 32'(keyin), 32'(exp));
            if (k == v.clear - 1) check($sformatf("v%0d busy s%0d", idx, k), 32'(busy), 32'(1));
            if (k == v.clear)     check($sformatf("v%0d busy s%0d", idx, k), 32'(busy), 32'(0));
        end
    endtask

    initial begin
        int         k;
        int         nruns;
        logic [7:0] prev;
        logic [7:0] cur;
        logic [7:0] exp;

        reset       = 1'b1;
        uart_strobe = 1'b0;
        uart_data   = 8'h00;
        keyrow      = 4'd0;

        //           data   row  first last low    clear
        vecs[0]  = '{8'h41, 4'd4,  4, 11, 8'hFE, 16};   // 'A' row 4 col 0
        vecs[1]  = '{8'h41, 4'd3,  0, -1, 8'hFF, 16};   // 'A' seen from another row
        vecs[2]  = '{8'h21, 4'd8,  4, 19, 8'hFE, 23};   // '!' shift lead/press/release
        vecs[3]  = '{8'h21, 4'd6,  8, 15, 8'hBF, 23};   // '!' main key = '1'
        vecs[4]  = '{8'h0D, 4'd6,  4, 11, 8'hDF, 16};   // RETURN row 6 col 5
`ifdef PET2001_KEY_SCHED_LF_DROP_EN
        vecs[5]  = '{8'h0A, 4'd6,  0, -1, 8'hFF, 1};    // LF dropped
`else
        vecs[5]  = '{8'h0A, 4'd6,  4, 11, 8'hDF, 16};   // LF typed as RETURN
`endif
        vecs[6]  = '{8'h7F, 4'd4,  0, -1, 8'hFF, 3};    // unmapped
        vecs[7]  = '{8'h61, 4'd4,  8, 15, 8'hFE, 23};   // 'a' = shift+A
        vecs[8]  = '{8'h5A, 4'd6,  4, 11, 8'hFE, 16};   // 'Z' row 6 col 0
        vecs[9]  = '{8'h20, 4'd9,  4, 11, 8'hFB, 16};   // space row 9 col 2
        vecs[10] = '{8'h41, 4'd12, 0, -1, 8'hFF, 16};   // row out of range
        vecs[11] = '{8'h28, 4'd3,  8, 15, 8'hBF, 23};   // '(' = shift+8

        burst_b   = '{8'h41, 8'h44, 8'h47, 8'h4A, 8'h4C, 8'h36};
        burst_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hBF};

        #1;
        check("reset keyin", 32'(keyin), 32'hFF);
        check("reset busy", 32'(busy), 32'(0));
        check("reset overflow", 32'(overflow), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
            wait_idle($sformatf("v%0d", i));
        end

        // Unmapped 0x7F immediately followed by 'A'
        @(negedge clk);
        keyrow      = 4'd4;
        uart_data   = 8'h7F;
        uart_strobe = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            exp = (j >= 6 && j <= 13) ? 8'hFE : 8'hFF;
            check($sformatf("unmapped keyin s%0d", j), 32'(keyin), 32'(exp));
            if (j == 1) begin
                uart_data   = 8'h41;
                uart_strobe = 1'b1;
            end else begin
                uart_strobe = 1'b0;
            end
        end
        wait_idle("unmapped");

        // Six back-to-back strobes, then one more exactly when full and popping
        @(negedge clk);
        keyrow      = 4'd4;
        uart_data   = burst_b[0];
        uart_strobe = 1'b1;
        k     = 0;
        nruns = 0;
        prev  = 8'hFF;
        while (k < 300) begin
            @(negedge clk);
            k++;
            cur = keyin;
            if (cur != 8'hFF) begin
                if (cur != prev) begin
                    if (nruns < 8) begin
                        run_val[nruns] = cur;
                        run_len[nruns] = 1;
                    end
                    nruns++;
                end else if (nruns >= 1 && nruns <= 8) begin
                    run_len[nruns-1]++;
                end
            end
            prev = cur;
            if (k == 5) check("burst overflow s5", 32'(overflow), 32'(0));
            if (k == 6) check("burst overflow s6", 32'(overflow), 32'(1));
            if (k < 6) begin
                uart_data   = burst_b[k];
                uart_strobe = 1'b1;
            end else if (k == 16) begin
                uart_data   = 8'h34;
                uart_strobe = 1'b1;
            end else begin
                uart_strobe = 1'b0;
            end
            if (k > 20 && !busy) break;
        end
        uart_strobe = 1'b0;
        check("burst completes", 32'(busy), 32'(0));
        check("burst run count", 32'(nruns), 32'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < nruns) begin
                check($sformatf("burst run%0d key", i), 32'(run_val[i]), 32'(burst_exp[i]));
                check($sformatf("burst run%0d len", i), 32'(run_len[i]), 32'(8));
            end else begin
                check($sformatf("burst run%0d missing", i), 32'(nruns), 32'(6));
            end
        end
        check("overflow sticky", 32'(overflow), 32'(1));

        // Reset in the middle of PRESS
        @(negedge clk);
        keyrow      = 4'd4;
        uart_data   = 8'h41;
        uart_strobe = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            uart_strobe = 1'b0;
        end
        check("pre-reset keyin", 32'(keyin), 32'hFE);
        check("pre-reset overflow", 32'(overflow), 32'(1));
        reset = 1'b1;
        #1;
        check("mid-press reset keyin", 32'(keyin), 32'hFF);
        check("mid-press reset busy", 32'(busy), 32'(0));
        check("mid-press reset overflow", 32'(overflow), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check($sformatf("post-reset keyin s%0d", j), 32'(keyin), 32'hFF);
            check($sformatf("post-reset busy s%0d", j), 32'(busy), 32'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
